// File: rtl/vslc_scan_sequencer.sv
// Scan sequencer: samples input banks, starts the logic core, then drives output banks.
// Optional watchdog is compiled in when VSLC_SCAN_WDT_EN is defined.
module vslc_scan_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int SLOT_CYCLES = 4,
    parameter int WDT_LIMIT   = 1024,
    localparam int BW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [BW-1:0] bank_addr,
    output logic          addr_strobe,
    output logic          bus_dir,
    input  logic [7:0]    in_bus,
    output logic [7:0]    out_bus,
    output logic          exec_start,
    input  logic          exec_done,
    input  logic [BW-1:0] img_rd_bank,
    output logic [7:0]    img_rd_data,
    input  logic          img_wr_en,
    input  logic [BW-1:0] img_wr_bank,
    input  logic [7:0]    img_wr_data,
    output logic          scan_cycle_clk,
    output logic          wdt_fault,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INPUT  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam logic [7:0]    SLOT_LAST = 8'(SLOT_CYCLES - 1);
    localparam logic [BW-1:0] BANK_LAST = BW'(CHANNELS - 1);
    localparam logic [BW:0]   CH_LIM    = (BW + 1)'(CHANNELS);

    state_t        state_q;
    logic [BW-1:0] bank_q;
    logic [7:0]    slot_q;
    logic          addr_strobe_q;
    logic          exec_start_q;
    logic          scan_clk_q;
    logic [7:0]    in_img_q  [CHANNELS];
    logic [7:0]    out_img_q [CHANNELS];
    logic          rd_ok;
    logic          wr_ok;

`ifdef VSLC_SCAN_WDT_EN
    localparam int          WW       = $clog2(WDT_LIMIT + 1);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_LIMIT - 1);
    logic          wdt_fault_q;
    logic [WW-1:0] wdt_cnt_q;
    assign wdt_fault = wdt_fault_q;
`else
    // Watchdog compiled out: the fault flag is a constant low.
    assign wdt_fault = (WDT_LIMIT < 0);
`endif

    assign rd_ok = ({1'b0, img_rd_bank} < CH_LIM);
    assign wr_ok = ({1'b0, img_wr_bank} < CH_LIM);

    assign bank_addr      = bank_q;
    assign addr_strobe    = addr_strobe_q;
    assign bus_dir        = (state_q == ST_OUTPUT);
    assign exec_start     = exec_start_q;
    assign scan_cycle_clk = scan_clk_q;
    assign dbg_state      = state_q;
    assign img_rd_data    = rd_ok ? in_img_q[img_rd_bank] : 8'h00;

    always_comb begin
        out_bus = 8'h00;
        if (state_q == ST_OUTPUT) begin
            out_bus = out_img_q[bank_q];
        end
    end

    // Core handshake: exec_start pulses on the first EXEC cycle; exec_done is sampled in
    // every EXEC cycle including that one, the first high sample ends EXEC, and it is ignored elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bank_q        <= '0;
            slot_q        <= 8'd0;
            addr_strobe_q <= 1'b0;
            exec_start_q  <= 1'b0;
            scan_clk_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                in_img_q[i]  <= 8'h00;
                out_img_q[i] <= 8'h00;
            end
`ifdef VSLC_SCAN_WDT_EN
            wdt_fault_q <= 1'b0;
            wdt_cnt_q   <= '0;
`endif
        end else begin
            addr_strobe_q <= 1'b0;
            exec_start_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable && !wdt_fault) begin
                        state_q       <= ST_INPUT;
                        bank_q        <= '0;
                        slot_q        <= 8'd0;
                        addr_strobe_q <= 1'b1;
                    end
                end
                ST_INPUT: begin
                    if (slot_q == SLOT_LAST) begin
                        in_img_q[bank_q] <= in_bus;
                        slot_q           <= 8'd0;
                        if (bank_q == BANK_LAST) begin
                            state_q      <= ST_EXEC;
                            bank_q       <= '0;
                            exec_start_q <= 1'b1;
`ifdef VSLC_SCAN_WDT_EN
                            wdt_cnt_q    <= '0;
`endif
                        end else begin
                            bank_q        <= bank_q + 1'b1;
                            addr_strobe_q <= 1'b1;
                        end
                    end else begin
                        slot_q <= slot_q + 8'd1;
                    end
                end
                ST_EXEC: begin
                    if (img_wr_en && wr_ok) begin
                        out_img_q[img_wr_bank] <= img_wr_data;
                    end
                    if (exec_done) begin
                        state_q       <= ST_OUTPUT;
                        bank_q        <= '0;
                        slot_q        <= 8'd0;
                        addr_strobe_q <= 1'b1;
                    end
`ifdef VSLC_SCAN_WDT_EN
                    // Timeout: blank the output image so the forced pass drives zeros.
                    else if (wdt_cnt_q == WDT_LAST) begin
                        wdt_fault_q   <= 1'b1;
                        state_q       <= ST_OUTPUT;
                        bank_q        <= '0;
                        slot_q        <= 8'd0;
                        addr_strobe_q <= 1'b1;
                        for (int i = 0; i < CHANNELS; i++) begin
                            out_img_q[i] <= 8'h00;
                        end
                    end else begin
                        wdt_cnt_q <= wdt_cnt_q + 1'b1;
                    end
`endif
                end
                ST_OUTPUT: begin
                    if (slot_q == SLOT_LAST) begin
                        slot_q <= 8'd0;
                        if (bank_q == BANK_LAST) begin
                            scan_clk_q <= ~scan_clk_q;
                            bank_q     <= '0;
                            if (enable && !wdt_fault) begin
                                state_q       <= ST_INPUT;
                                addr_strobe_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            bank_q        <= bank_q + 1'b1;
                            addr_strobe_q <= 1'b1;
                        end
                    end else begin
                        slot_q <= slot_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Directed bench for vslc_scan_sequencer: scoreboarded image contents, slot timing, reset and watchdog.
`timescale 1ns/100ps
module tb_vslc_scan_sequencer;

    localparam int CH = 4;
    localparam int SC = 2;
    localparam int WL = 16;
    localparam int BW = 2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_INPUT  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          exec_done = 1'b0;
    logic          img_wr_en = 1'b0;
    logic [7:0]    in_bus = 8'h00;
    logic [7:0]    img_wr_data = 8'h00;
    logic [BW-1:0] img_rd_bank = '0;
    logic [BW-1:0] img_wr_bank = '0;
    logic [1:0]    u3_rd_bank = 2'd3;

    logic [BW-1:0] bank_addr;
    logic          addr_strobe, bus_dir, exec_start, scan_cycle_clk, wdt_fault;
    logic [7:0]    out_bus, img_rd_data;
    logic [1:0]    dbg_state;

    logic [1:0]    u3_bank_addr, u3_dbg_state;
    logic          u3_strobe, u3_dir, u3_exec_start, u3_scan_clk, u3_wdt;
    logic [7:0]    u3_out_bus, u3_rd_data;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] in_model  [CH];
    logic [7:0] out_model [CH];
    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];

    vslc_scan_sequencer #(.CHANNELS(CH), .SLOT_CYCLES(SC), .WDT_LIMIT(WL)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .bank_addr(bank_addr), .addr_strobe(addr_strobe), .bus_dir(bus_dir),
        .in_bus(in_bus), .out_bus(out_bus),
        .exec_start(exec_start), .exec_done(exec_done),
        .img_rd_bank(img_rd_bank), .img_rd_data(img_rd_data),
        .img_wr_en(img_wr_en), .img_wr_bank(img_wr_bank), .img_wr_data(img_wr_data),
        .scan_cycle_clk(scan_cycle_clk), .wdt_fault(wdt_fault), .dbg_state(dbg_state)
    );

    // Three-bank instance: bank index 3 is representable but out of range.
    vslc_scan_sequencer #(.CHANNELS(3), .SLOT_CYCLES(SC), .WDT_LIMIT(WL)) u_dut3 (
        .clk(clk), .rst(rst), .enable(enable),
        .bank_addr(u3_bank_addr), .addr_strobe(u3_strobe), .bus_dir(u3_dir),
        .in_bus(in_bus), .out_bus(u3_out_bus),
        .exec_start(u3_exec_start), .exec_done(exec_done),
        .img_rd_bank(u3_rd_bank), .img_rd_data(u3_rd_data),
        .img_wr_en(img_wr_en), .img_wr_bank(img_wr_bank), .img_wr_data(img_wr_data),
        .scan_cycle_clk(u3_scan_clk), .wdt_fault(u3_wdt), .dbg_state(u3_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, dbg_state, S_IDLE);
        check({tag, "_bank"}, bank_addr, 0);
        check({tag, "_strobe"}, addr_strobe, 0);
        check({tag, "_dir"}, bus_dir, 0);
        check({tag, "_out_bus"}, out_bus, 0);
        check({tag, "_exec_start"}, exec_start, 0);
        check({tag, "_scan_clk"}, scan_cycle_clk, 0);
        check({tag, "_wdt"}, wdt_fault, 0);
        for (int b = 0; b < CH; b++) begin
            img_rd_bank = BW'(b);
            #1;
            check({tag, "_in_img"}, img_rd_data, 0);
        end
    endtask

    // Follows one scan cycle from its first INPUT cycle; stimulus and expectations per slot.
    task automatic scan_pass(input logic [7:0] base, input int done_at, input logic do_wr,
                             input logic [1:0] wr_bank, input logic [7:0] wr_data,
                             input int drop_bank, input int rst_bank, input logic exp_wdt);
        logic       sc_prev;
        logic [7:0] exp_o;
        int         len;
        int         exec_lim;
        sc_prev = scan_cycle_clk;
        len = 0;
        for (int b = 0; b < CH; b++) begin
            for (int s = 0; s < SC; s++) begin
                if (b == drop_bank && s == 0) enable = 1'b0;
                check("in_state", dbg_state, S_INPUT);
                check("in_bank", bank_addr, b);
                check("in_strobe", addr_strobe, (s == 0));
                check("in_dir", bus_dir, 0);
                check("in_out_bus", out_bus, 0);
                in_bus = base + 8'(b);
                img_wr_en = 1'b1;
                img_wr_bank = BW'(b);
                img_wr_data = 8'hEE;
                exec_done = 1'b1;
                if (s == SC - 1) begin
                    img_rd_bank = BW'(b);
                    #1;
                    check("rd_old_value", img_rd_data, in_model[b]);
                    in_model[b] = in_bus;
                    in_q.push_back(in_bus);
                end
                tick();
                len++;
            end
        end
        img_wr_en = 1'b0;
        exec_done = 1'b0;
        exec_lim = exp_wdt ? WL : done_at + 1;
        for (int k = 0; k < exec_lim; k++) begin
            check("ex_state", dbg_state, S_EXEC);
            check("ex_start", exec_start, (k == 0));
            check("ex_out_bus", out_bus, 0);
            check("ex_wdt", wdt_fault, 0);
            img_wr_en = 1'b0;
            if (k == 0) begin
                for (int b = 0; b < CH; b++) begin
                    img_rd_bank = BW'(b);
                    #1;
                    check("in_img", img_rd_data, in_q.pop_front());
                end
                if (do_wr) begin
                    img_wr_en = 1'b1;
                    img_wr_bank = wr_bank;
                    img_wr_data = wr_data;
                    out_model[wr_bank] = wr_data;
                end
            end
            exec_done = (!exp_wdt && k == done_at);
            tick();
            len++;
        end
        exec_done = 1'b0;
        img_wr_en = 1'b0;
        if (exp_wdt) out_model = '{default: 8'h00};
        check("wdt_after_exec", wdt_fault, exp_wdt);
        for (int b = 0; b < CH; b++) exp_q.push_back(out_model[b]);
        for (int b = 0; b < CH; b++) begin
            exp_o = exp_q.pop_front();
            for (int s = 0; s < SC; s++) begin
                check("out_state", dbg_state, S_OUTPUT);
                check("out_bank", bank_addr, b);
                check("out_strobe", addr_strobe, (s == 0));
                check("out_dir", bus_dir, 1);
                check("out_bus", out_bus, exp_o);
                check("scan_hold", scan_cycle_clk, sc_prev);
                if (b == rst_bank && s == 0) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    check_reset_outputs("mid_rst");
                    in_model = '{default: 8'h00};
                    out_model = '{default: 8'h00};
                    in_q.delete();
                    exp_q.delete();
                    return;
                end
                img_wr_en = 1'b1;
                img_wr_bank = BW'(b);
                img_wr_data = 8'h77;
                exec_done = 1'b1;
                tick();
                len++;
            end
        end
        img_wr_en = 1'b0;
        exec_done = 1'b0;
        check("scan_toggle", scan_cycle_clk, !sc_prev);
        check("cycle_len", len, 2 * CH * SC + exec_lim);
        check("next_state", dbg_state, (enable && !exp_wdt) ? S_INPUT : S_IDLE);
        check("next_bank", bank_addr, 0);
    endtask

    initial begin
        in_model = '{default: 8'h00};
        out_model = '{default: 8'h00};

        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_hold", dbg_state, S_IDLE);

        enable = 1'b1;
        tick();
        check("start_input", dbg_state, S_INPUT);
        scan_pass(8'hA0, 2, 1'b1, 2'd2, 8'h5A, -1, -1, 1'b0);
        scan_pass(8'($urandom_range(0, 255)), 0, 1'b1, 2'd0, 8'($urandom_range(0, 255)), -1, -1, 1'b0);
        scan_pass(8'($urandom_range(0, 255)), 5, 1'b0, 2'd0, 8'h00, 1, -1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_after_drop", dbg_state, S_IDLE);
            check("idle_strobe", addr_strobe, 0);
        end

        enable = 1'b1;
        tick();
        scan_pass(8'($urandom_range(0, 255)), 1, 1'b1, 2'd3, 8'hC3, -1, 1, 1'b0);
        tick();
        check("restart_after_rst", dbg_state, S_INPUT);
        scan_pass(8'($urandom_range(0, 255)), 1, 1'b0, 2'd0, 8'h00, 0, -1, 1'b0);

        enable = 1'b1;
        tick();
`ifdef VSLC_SCAN_WDT_EN
        scan_pass(8'($urandom_range(0, 255)), 0, 1'b1, 2'd1, 8'h33, -1, -1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wdt_idle", dbg_state, S_IDLE);
            check("wdt_sticky", wdt_fault, 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wdt_cleared", wdt_fault, 0);
        tick();
        check("wdt_restart", dbg_state, S_INPUT);
        enable = 1'b0;
`else
        scan_pass(8'($urandom_range(0, 255)), 40, 1'b1, 2'd1, 8'h33, 0, -1, 1'b0);
        check("no_wdt", wdt_fault, 0);
`endif

        check("oob_read", u3_rd_data, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
